// File: rtl/tt_mask_idx_rcvr_if.sv
// Mask/index receiver bus: sender push + credit return, memop control,
// element stream to the consumer, status. slave = receiver, master = driver.
interface tt_mask_idx_rcvr_if #(
    parameter int VLEN = 256
);
    localparam int VLW = $clog2(VLEN + 1);

    logic           i_mask_idx_valid;
    logic [64:0]    i_mask_idx_item;
    logic           i_mask_idx_last_idx;
    logic           i_start;
    logic           i_is_indexed;
    logic [VLW-1:0] i_vl;
    logic           i_elem_ready;

    logic           o_mask_idx_credit;
    logic           o_elem_valid;
    logic           o_elem_mask;
    logic [63:0]    o_elem_index;
    logic           o_elem_last;
    logic           o_busy;
    logic [1:0]     o_err;

    modport slave (
        input  i_mask_idx_valid,
        input  i_mask_idx_item,
        input  i_mask_idx_last_idx,
        input  i_start,
        input  i_is_indexed,
        input  i_vl,
        input  i_elem_ready,
        output o_mask_idx_credit,
        output o_elem_valid,
        output o_elem_mask,
        output o_elem_index,
        output o_elem_last,
        output o_busy,
        output o_err
    );

    modport master (
        output i_mask_idx_valid,
        output i_mask_idx_item,
        output i_mask_idx_last_idx,
        output i_start,
        output i_is_indexed,
        output i_vl,
        output i_elem_ready,
        input  o_mask_idx_credit,
        input  o_elem_valid,
        input  o_elem_mask,
        input  o_elem_index,
        input  o_elem_last,
        input  o_busy,
        input  o_err
    );
endinterface

// File: rtl/tt_mask_idx_rcvr.sv
// Mask/index receiver: credit-based FIFO of mask/index items, expanded into
// one element per accept (indexed: one item each; strided: 64 mask bits).
// Ports: i_clk, i_reset (async, active-high), bus (tt_mask_idx_rcvr_if.slave):
//   push side (valid/item/last_idx, credit out), start/is_indexed/vl,
//   element stream (valid/mask/index/last, ready in), busy, sticky err[1:0].
module tt_mask_idx_rcvr #(
    parameter int VLEN         = 256,
    parameter int MASK_CREDITS = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    tt_mask_idx_rcvr_if.slave bus
);
    localparam int VLW   = $clog2(VLEN + 1);
    localparam int DEPTH = MASK_CREDITS;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = 66;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e         state_q, state_d;
    logic [EW-1:0]  mem_q [DEPTH];
    logic [EW-1:0]  mem_d [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           is_idx_q, is_idx_d;
    logic [VLW-1:0] vl_q, vl_d;
    logic [VLW-1:0] elem_cnt_q, elem_cnt_d;
    logic [5:0]     bit_ptr_q, bit_ptr_d;
    logic           credit_q, credit_d;
    logic [1:0]     err_q, err_d;

    logic           fifo_empty;
    logic           fifo_full;
    logic [64:0]    head_item;
    logic [63:0]    head_word;
    logic           head_last;
    logic [VLW-1:0] last_cnt;
    logic           elem_valid;
    logic           elem_last;
    logic           accept;
    logic           pop;
    logic           push;
    logic           overflow;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Each entry is {item[64:0], last_idx}.
    assign head_item  = mem_q[rd_ptr_q][65:1];
    assign head_last  = mem_q[rd_ptr_q][0];
    assign head_word  = head_item[63:0];

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(DEPTH));

    assign last_cnt   = vl_q - 1'b1;
    assign elem_valid = (state_q == RUN) && !fifo_empty;
    assign elem_last  = elem_valid && (elem_cnt_q == last_cnt);
    assign accept     = elem_valid && bus.i_elem_ready;

    // Strided words are retired after bit 63 or on the memop's last element.
    assign pop = accept &&
                 (is_idx_q || (bit_ptr_q == 6'd63) || elem_last);

    // A full FIFO can still take a push when the head leaves this cycle.
    assign push     = bus.i_mask_idx_valid && (!fifo_full || pop);
    assign overflow = bus.i_mask_idx_valid && fifo_full && !pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.i_mask_idx_item, bus.i_mask_idx_last_idx};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        is_idx_d   = is_idx_q;
        vl_d       = vl_q;
        elem_cnt_d = elem_cnt_q;
        bit_ptr_d  = bit_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start && (bus.i_vl != '0)) begin
                    state_d    = RUN;
                    is_idx_d   = bus.i_is_indexed;
                    vl_d       = bus.i_vl;
                    elem_cnt_d = '0;
                    bit_ptr_d  = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    elem_cnt_d = elem_cnt_q + 1'b1;
                    bit_ptr_d  = pop ? 6'd0 : bit_ptr_q + 6'd1;
                    if (elem_last) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        err_d    = err_q;
        credit_d = pop;
        if (overflow) begin
            err_d[0] = 1'b1;
        end
        if (pop && is_idx_q && (head_last != elem_last)) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            is_idx_q   <= 1'b0;
            vl_q       <= '0;
            elem_cnt_q <= '0;
            bit_ptr_q  <= '0;
            credit_q   <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            is_idx_q   <= is_idx_d;
            vl_q       <= vl_d;
            elem_cnt_q <= elem_cnt_d;
            bit_ptr_q  <= bit_ptr_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
        end
    end

    // Data outputs are gated so nothing leaks while no element is offered.
    assign bus.o_mask_idx_credit = credit_q;
    assign bus.o_elem_valid      = elem_valid;
    assign bus.o_elem_mask       = elem_valid &&
                                   (is_idx_q ? head_item[64]
                                             : head_word[bit_ptr_q]);
    assign bus.o_elem_index      = (elem_valid && is_idx_q) ? head_word
                                                            : 64'd0;
    assign bus.o_elem_last       = elem_last;
    assign bus.o_busy            = (state_q == RUN);
    assign bus.o_err             = err_q;
endmodule

// File: tb/tb_tt_mask_idx_rcvr.sv
// Directed bench for tt_mask_idx_rcvr: indexed, strided, backpressure,
// full with pop/push, protocol error, idle push, reset mid-op.
module tb_tt_mask_idx_rcvr;
    localparam int VLEN = 256;

    logic clk = 1'b0;
    logic rst;

    tt_mask_idx_rcvr_if #(.VLEN(VLEN)) bus ();

    tt_mask_idx_rcvr #(
        .VLEN(VLEN),
        .MASK_CREDITS(2)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_credit = 0;
    bit          acc_mask [$];
    logic [63:0] acc_idx  [$];
    bit          acc_last [$];

    always @(negedge clk) begin
        if (bus.o_mask_idx_credit) n_credit++;
        if (bus.o_elem_valid && bus.i_elem_ready) begin
            acc_mask.push_back(bus.o_elem_mask);
            acc_idx.push_back(bus.o_elem_index);
            acc_last.push_back(bus.o_elem_last);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_on(input logic [64:0] item, input logic lst);
        bus.i_mask_idx_valid    = 1'b1;
        bus.i_mask_idx_item     = item;
        bus.i_mask_idx_last_idx = lst;
    endtask

    task automatic push_off();
        bus.i_mask_idx_valid    = 1'b0;
        bus.i_mask_idx_item     = '0;
        bus.i_mask_idx_last_idx = 1'b0;
    endtask

    task automatic start(input logic idx, input int vl);
        bus.i_start      = 1'b1;
        bus.i_is_indexed = idx;
        bus.i_vl         = 9'(vl);
    endtask

    task automatic clear_mon();
        n_credit = 0;
        acc_mask.delete();
        acc_idx.delete();
        acc_last.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && bus.o_busy; i++) tick();
        chk(tag, 64'(bus.o_busy), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic chk_zero_outs(input string pfx);
        chk({pfx, "_valid"}, 64'(bus.o_elem_valid), 64'd0);
        chk({pfx, "_mask"}, 64'(bus.o_elem_mask), 64'd0);
        chk({pfx, "_index"}, bus.o_elem_index, 64'd0);
        chk({pfx, "_last"}, 64'(bus.o_elem_last), 64'd0);
        chk({pfx, "_credit"}, 64'(bus.o_mask_idx_credit), 64'd0);
        chk({pfx, "_busy"}, 64'(bus.o_busy), 64'd0);
        chk({pfx, "_err"}, 64'(bus.o_err), 64'd0);
    endtask

    logic [63:0] exp_idx  [3] = '{64'h10, 64'h20, 64'h30};
    bit          exp_mask [3] = '{1'b1, 1'b0, 1'b1};
    bit          exp_last [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        int ones;
        int lasts;
        logic [63:0] idx_or;

        rst = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_is_indexed = 1'b0;
        bus.i_vl         = '0;
        bus.i_elem_ready = 1'b0;
        push_off();
        tick();
        tick();
        chk_zero_outs("rst");
        rst = 1'b0;
        tick();

        // Indexed, vl=3
        clear_mon();
        bus.i_elem_ready = 1'b1;
        start(1'b1, 3);
        push_on(65'h1_0000000000000010, 1'b0);
        tick();
        bus.i_start = 1'b0;
        push_on(65'h0_0000000000000020, 1'b0);
        tick();
        push_on(65'h1_0000000000000030, 1'b1);
        tick();
        push_off();
        wait_idle("idx_idle", 20);
        repeat (2) tick();
        chk("idx_n", 64'(acc_mask.size()), 64'd3);
        if (acc_mask.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("idx_mask%0d", i), 64'(acc_mask[i]),
                    64'(exp_mask[i]));
                chk($sformatf("idx_index%0d", i), acc_idx[i], exp_idx[i]);
                chk($sformatf("idx_last%0d", i), 64'(acc_last[i]),
                    64'(exp_last[i]));
            end
        end
        chk("idx_credits", 64'(n_credit), 64'd3);
        chk("idx_err", 64'(bus.o_err), 64'd0);

        // Strided, vl=70
        clear_mon();
        start(1'b0, 70);
        push_on(65'h0_FFFFFFFFFFFFFFFF, 1'b0);
        tick();
        bus.i_start = 1'b0;
        push_on(65'h0_000000000000003F, 1'b1);
        tick();
        push_off();
        wait_idle("str_idle", 300);
        repeat (3) tick();
        ones = 0;
        lasts = 0;
        idx_or = '0;
        foreach (acc_mask[i]) begin
            ones += int'(acc_mask[i]);
            lasts += int'(acc_last[i]);
            idx_or |= acc_idx[i];
        end
        chk("str_n", 64'(acc_mask.size()), 64'd70);
        chk("str_ones", 64'(ones), 64'd70);
        chk("str_lasts", 64'(lasts), 64'd1);
        if (acc_last.size() == 70)
            chk("str_last69", 64'(acc_last[69]), 64'd1);
        chk("str_index", idx_or, 64'd0);
        chk("str_credits", 64'(n_credit), 64'd2);
        chk("str_err", 64'(bus.o_err), 64'd0);

        // Backpressure, then overflow
        clear_mon();
        bus.i_elem_ready = 1'b0;
        start(1'b1, 2);
        push_on(65'h0_00000000000000AA, 1'b0);
        tick();
        bus.i_start = 1'b0;
        push_on(65'h1_00000000000000BB, 1'b1);
        tick();
        push_off();
        chk("bp_busy", 64'(bus.o_busy), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_valid%0d", i), 64'(bus.o_elem_valid), 64'd1);
            chk($sformatf("bp_head%0d", i), bus.o_elem_index, 64'hAA);
            tick();
        end
        chk("bp_credits", 64'(n_credit), 64'd0);
        push_on(65'h1_00000000000000CC, 1'b0);
        tick();
        push_off();
        chk("bp_ovf", 64'(bus.o_err), 64'd1);
        bus.i_elem_ready = 1'b1;
        wait_idle("bp_idle", 20);
        repeat (2) tick();
        chk("bp_n", 64'(acc_idx.size()), 64'd2);
        if (acc_idx.size() == 2) begin
            chk("bp_idx0", acc_idx[0], 64'hAA);
            chk("bp_idx1", acc_idx[1], 64'hBB);
            chk("bp_last1", 64'(acc_last[1]), 64'd1);
        end
        chk("bp_credits2", 64'(n_credit), 64'd2);
        chk("bp_err_sticky", 64'(bus.o_err), 64'd1);
        do_reset();
        chk("bp_err_rst", 64'(bus.o_err), 64'd0);

        // Full FIFO with simultaneous pop and push
        clear_mon();
        bus.i_elem_ready = 1'b0;
        start(1'b1, 3);
        push_on(65'h1_00000000000000A1, 1'b0);
        tick();
        bus.i_start = 1'b0;
        push_on(65'h0_00000000000000B2, 1'b0);
        tick();
        bus.i_elem_ready = 1'b1;
        push_on(65'h1_00000000000000C3, 1'b1);
        tick();
        bus.i_elem_ready = 1'b0;
        push_off();
        chk("pp_err", 64'(bus.o_err), 64'd0);
        chk("pp_head", bus.o_elem_index, 64'hB2);
        tick();
        tick();
        chk("pp_credit1", 64'(n_credit), 64'd1);
        bus.i_elem_ready = 1'b1;
        wait_idle("pp_idle", 20);
        repeat (2) tick();
        chk("pp_n", 64'(acc_idx.size()), 64'd3);
        if (acc_idx.size() == 3) begin
            chk("pp_idx1", acc_idx[1], 64'hB2);
            chk("pp_idx2", acc_idx[2], 64'hC3);
            chk("pp_last2", 64'(acc_last[2]), 64'd1);
        end
        chk("pp_credits", 64'(n_credit), 64'd3);
        chk("pp_err_end", 64'(bus.o_err), 64'd0);

        // last_idx mismatch
        clear_mon();
        start(1'b1, 2);
        push_on(65'h1_0000000000000011, 1'b1);
        tick();
        bus.i_start = 1'b0;
        push_on(65'h0_0000000000000022, 1'b1);
        tick();
        push_off();
        wait_idle("pe_idle", 20);
        repeat (2) tick();
        chk("pe_err", 64'(bus.o_err), 64'd2);
        repeat (5) tick();
        chk("pe_err_hold", 64'(bus.o_err), 64'd2);

        // vl=0 start ignored; item pushed while idle is kept
        clear_mon();
        start(1'b1, 0);
        push_on(65'h1_000000000000005A, 1'b1);
        tick();
        bus.i_start = 1'b0;
        push_off();
        tick();
        chk("vl0_busy", 64'(bus.o_busy), 64'd0);
        chk("vl0_valid", 64'(bus.o_elem_valid), 64'd0);
        chk("vl0_n", 64'(acc_idx.size()), 64'd0);
        start(1'b1, 1);
        tick();
        bus.i_start = 1'b0;
        wait_idle("vl1_idle", 20);
        repeat (2) tick();
        chk("vl1_n", 64'(acc_idx.size()), 64'd1);
        if (acc_idx.size() == 1) begin
            chk("vl1_idx", acc_idx[0], 64'h5A);
            chk("vl1_last", 64'(acc_last[0]), 64'd1);
        end
        chk("vl1_credits", 64'(n_credit), 64'd1);
        chk("vl1_err", 64'(bus.o_err), 64'd2);
        do_reset();
        chk("pe_err_rst", 64'(bus.o_err), 64'd0);

        // Reset mid-op
        clear_mon();
        bus.i_elem_ready = 1'b0;
        start(1'b1, 4);
        push_on(65'h1_0000000000000001, 1'b0);
        tick();
        bus.i_start = 1'b0;
        push_on(65'h1_0000000000000002, 1'b0);
        tick();
        push_off();
        bus.i_elem_ready = 1'b1;
        tick();
        bus.i_elem_ready = 1'b0;
        tick();
        chk("rm_n", 64'(acc_idx.size()), 64'd1);
        chk("rm_credit", 64'(n_credit), 64'd1);
        chk("rm_valid_pre", 64'(bus.o_elem_valid), 64'd1);
        rst = 1'b1;
        bus.i_elem_ready = 1'b1;
        #1;
        chk_zero_outs("rm");
        repeat (3) tick();
        chk("rm_credit_hold", 64'(n_credit), 64'd1);
        rst = 1'b0;
        tick();
        clear_mon();
        start(1'b1, 2);
        push_on(65'h0_0000000000000077, 1'b0);
        tick();
        bus.i_start = 1'b0;
        push_on(65'h1_0000000000000088, 1'b1);
        tick();
        push_off();
        wait_idle("rc_idle", 20);
        repeat (2) tick();
        chk("rc_n", 64'(acc_idx.size()), 64'd2);
        if (acc_idx.size() == 2) begin
            chk("rc_idx0", acc_idx[0], 64'h77);
            chk("rc_mask0", 64'(acc_mask[0]), 64'd0);
            chk("rc_idx1", acc_idx[1], 64'h88);
            chk("rc_mask1", 64'(acc_mask[1]), 64'd1);
        end
        chk("rc_credits", 64'(n_credit), 64'd2);
        chk("rc_err", 64'(bus.o_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end
endmodule
